// File: rtl/adder4_seq_ctrl.sv
// adder4_seq_ctrl: wide unsigned adder built from one 4-bit ripple slice, one nibble per cycle
//
// adder4 ports:
//   a, b   in   4-bit addends
//   ci     in   carry-in
//   s      out  4-bit sum
//   co     out  carry-out
//
// adder4_seq_ctrl ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   ena         in   clock enable; 0 freezes all state and outputs
//   start       in   begin an addition (accepted only in IDLE)
//   op_a, op_b  in   W-bit operands, sampled on the accepting edge
//   cin         in   carry-in to nibble 0, sampled on the accepting edge
//   busy        out  high while iterating (see latency note below)
//   done        out  one enabled-cycle pulse when a result is presented
//   sum         out  W-bit result register
//   cout        out  carry-out of the MSB nibble

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;
    assign c[0] = ci;
    genvar i;
    for (i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[4];
endmodule

module adder4_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    wa;
    logic [W-1:0]    wb;
    logic [W-1:0]    ws;
    logic [W-1:0]    ws_next;
    logic [3:0]      na;
    logic [3:0]      nb;
    logic [3:0]      ns;
    logic            nc;

    // Shifts instead of variable part-selects keep the nibble mux width-clean.
    assign na = 4'(wa >> {idx, 2'b00});
    assign nb = 4'(wb >> {idx, 2'b00});

    adder4 u_slice (
        .a  (na),
        .b  (nb),
        .ci (carry),
        .s  (ns),
        .co (nc)
    );

    assign ws_next = (ws & ~(W'(4'hF) << {idx, 2'b00})) | (W'(ns) << {idx, 2'b00});

    // busy rises one edge after acceptance and drops on the last RUN edge,
    // so it is high for NIBBLES-1 cycles and never for a single-nibble build.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            wa    <= '0;
            wb    <= '0;
            ws    <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wa    <= op_a;
                        wb    <= op_b;
                        carry <= cin;
                        ws    <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ws    <= ws_next;
                    carry <= nc;
                    if (idx == LAST) begin
                        sum   <= ws_next;
                        cout  <= nc;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx  <= idx + 1'b1;
                        busy <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// tb_adder4_seq_ctrl: directed and random self-checking bench for adder4_seq_ctrl (NIBBLES=4)
module tb_adder4_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    int n_checks = 0;
    int n_fail = 0;

    adder4_seq_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one addition from IDLE and check latency, busy length and result.
    task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [15:0] es, input logic ec);
        int cnt;
        int bcnt;
        op_a = a;
        op_b = b;
        cin = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a = ~a;
        op_b = ~b;
        cnt = 0;
        bcnt = 0;
        while (!done && cnt < 20) begin
            if (busy) bcnt++;
            tick();
            cnt++;
        end
        check({tag, "_lat"}, cnt, 4);
        check({tag, "_busy"}, bcnt, 3);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        tick();
        check({tag, "_done_off"}, done, 0);
    endtask

    initial begin
        int cnt;
        int pulses;
        int since;
        logic [16:0] model;

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        run_add("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_add("cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        run_add("max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // start during RUN and DONE must be ignored
        op_a = 16'h00FF;
        op_b = 16'h0001;
        cin = 1'b0;
        start = 1'b1;
        tick();
        op_a = 16'h7777;
        op_b = 16'h1111;
        pulses = 0;
        cnt = 0;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        check("ign_lat", cnt, 4);
        check("ign_sum", sum, 16'h0100);
        check("ign_cout", cout, 0);
        tick();
        start = 1'b0;
        check("ign_done_off", done, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        check("ign_pulses", pulses, 0);
        check("ign_sum_hold", sum, 16'h0100);

        // three stalled cycles mid-RUN delay done by three; done stretches while stalled
        op_a = 16'h8888;
        op_b = 16'h8888;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ena = 1'b0;
        tick();
        tick();
        tick();
        ena = 1'b1;
        cnt = 4;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        check("ena_lat", cnt, 7);
        check("ena_sum", sum, 16'h1110);
        check("ena_cout", cout, 1);
        ena = 1'b0;
        tick();
        check("ena_done_hold", done, 1);
        ena = 1'b1;
        tick();
        check("ena_done_off", done, 0);

        // reset during RUN aborts without a done pulse
        op_a = 16'hAAAA;
        op_b = 16'h5555;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_done", done, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_pulses", pulses, 0);
        run_add("post_abort", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

        // back-to-back with start held high
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        cin = 1'($urandom);
        model = {1'b0, op_a} + {1'b0, op_b} + {16'b0, cin};
        start = 1'b1;
        since = 0;
        for (int n = 0; n < 1000; n++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
                since++;
            end while (!done && cnt < 20);
            if (n > 0) check("rnd_cadence", since, 6);
            check("rnd_res", {cout, sum}, model);
            since = 0;
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            cin = 1'($urandom);
            model = {1'b0, op_a} + {1'b0, op_b} + {16'b0, cin};
        end
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
